// File: rtl/des_final_permutation.sv
// DES output stage.
// Takes the round-16 halves, applies the optional pre-output swap and the
// final permutation (IP^-1), and buffers the permuted words in a small FIFO.
// The round engine can hand off a block and move on while the consumer
// drains the buffer through a valid/ready handshake.
//
// in_ready is a function of the registered occupancy only, so a full FIFO
// does not accept a push even when the consumer pops in the same cycle.
// This keeps out_ready off any combinational path to in_ready.

module des_final_permutation #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] left_half,
    input  logic [31:0] right_half,
    input  logic        swap_en,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] output_text,
    output logic [15:0] blk_cnt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [AW:0] COUNT_FULL  = (AW + 1)'(DEPTH);
    localparam logic [AW:0] COUNT_EMPTY = '0;

    // Final permutation table, 1-based source positions counted from the LSB
    // of the pre-output word: output bit j takes pre-output bit FP[j]-1.
    localparam int FP [64] = '{
        40,  8, 48, 16, 56, 24, 64, 32,
        39,  7, 47, 15, 55, 23, 63, 31,
        38,  6, 46, 14, 54, 22, 62, 30,
        37,  5, 45, 13, 53, 21, 61, 29,
        36,  4, 44, 12, 52, 20, 60, 28,
        35,  3, 43, 11, 51, 19, 59, 27,
        34,  2, 42, 10, 50, 18, 58, 26,
        33,  1, 41,  9, 49, 17, 57, 25
    };

    logic [63:0]   pre_w;
    logic [63:0]   perm_w;

    logic [63:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;
    logic [15:0]   blk_cnt_q, blk_cnt_d;

    logic          push_w;
    logic          pop_w;

    // Pre-output word: the halves in order, or exchanged when swap_en is set.
    assign pre_w = swap_en ? {right_half, left_half} : {left_half, right_half};

    // Pure wiring: each output bit is a fixed pre-output bit.
    for (genvar j = 0; j < 64; j++) begin : g_fp
        assign perm_w[j] = pre_w[FP[j] - 1];
    end

    // Handshake status comes from the registered occupancy only.
    assign in_ready  = (count_q != COUNT_FULL);
    assign out_valid = (count_q != COUNT_EMPTY);

    assign push_w = in_valid && in_ready;
    assign pop_w  = out_valid && out_ready;

    // The head entry is presented while valid; zero when empty so the output
    // is clean out of reset and after the FIFO drains.
    assign output_text = out_valid ? mem_q[rd_ptr_q] : 64'h0;
    assign blk_cnt     = blk_cnt_q;

    // Next-state for pointers, occupancy and the delivered-block counter.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        blk_cnt_d = blk_cnt_q;

        if (push_w) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_w) begin
            rd_ptr_d  = rd_ptr_q + 1'b1;
            blk_cnt_d = blk_cnt_q + 16'd1;
        end

        case ({push_w, pop_w})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control state; reset discards everything buffered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            blk_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            blk_cnt_q <= blk_cnt_d;
        end
    end

    // Storage holds already-permuted words; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_w) begin
            mem_q[wr_ptr_q] <= perm_w;
        end
    end

endmodule

// File: tb/tb_des_final_permutation.sv
module tb_des_final_permutation;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] left_half;
    logic [31:0] right_half;
    logic        swap_en;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] output_text;
    logic [15:0] blk_cnt;

    des_final_permutation #(.DEPTH(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .left_half   (left_half),
        .right_half  (right_half),
        .swap_en     (swap_en),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .output_text (output_text),
        .blk_cnt     (blk_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int FP [64] = '{
        40,  8, 48, 16, 56, 24, 64, 32,
        39,  7, 47, 15, 55, 23, 63, 31,
        38,  6, 46, 14, 54, 22, 62, 30,
        37,  5, 45, 13, 53, 21, 61, 29,
        36,  4, 44, 12, 52, 20, 60, 28,
        35,  3, 43, 11, 51, 19, 59, 27,
        34,  2, 42, 10, 50, 18, 58, 26,
        33,  1, 41,  9, 49, 17, 57, 25
    };

    typedef struct {
        logic [31:0] l;
        logic [31:0] r;
        logic        s;
        logic [63:0] exp;
        string       nm;
    } vec_t;

    int          total = 0;
    int          bad   = 0;
    logic [63:0] cur_exp = '0;
    logic [63:0] exp_q [$];
    logic [15:0] exp_blk = '0;
    int          pop_cnt = 0;
    int          stall_cnt = 0;
    int          cyc = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Initial permutation as the inverse scatter of the final-permutation table.
    function automatic logic [63:0] ip_of(input logic [63:0] x);
        logic [63:0] p;
        logic [5:0]  k;
        p = '0;
        for (int j = 0; j < 64; j++) begin
            k = 6'(FP[j] - 1);
            p[k] = x[6'(j)];
        end
        return p;
    endfunction

    // Scoreboard: every pop must match the oldest accepted block.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            exp_q.delete();
            exp_blk = '0;
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL stale_pop: got %h expected no block", output_text);
                end else begin
                    chk("fifo_order", output_text, exp_q.pop_front());
                end
                exp_blk = exp_blk + 16'd1;
                pop_cnt++;
            end
            if (in_valid && in_ready) exp_q.push_back(cur_exp);
            if (in_valid && !in_ready) stall_cnt++;
        end
    end

    // Present one block and hold it until accepted; called at posedge+1.
    task automatic push_blk(input logic [31:0] l, input logic [31:0] r,
                            input logic s, input logic [63:0] e);
        bit acc;
        int n;
        left_half  = l;
        right_half = r;
        swap_en    = s;
        cur_exp    = e;
        in_valid   = 1'b1;
        acc = 0;
        n   = 0;
        while (!acc && n < 20) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL push_timeout: got in_ready=0 for %0d cycles expected accept", n);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        vecs [9];
        logic [63:0] x, p;
        int          p0, s0, c0;

        vecs[0] = '{32'h0000_0080, 32'h0, 1'b0, 64'h0000_0000_0000_0001, "single_bit"};
        vecs[1] = '{32'h0000_0080, 32'h0, 1'b1, 64'h0000_0000_0000_0002, "swap_left"};
        vecs[2] = '{32'h0, 32'h0000_0080, 1'b0, 64'h0000_0000_0000_0002, "right_bit7"};
        vecs[3] = '{32'h0000_0001, 32'h0, 1'b0, 64'h0100_0000_0000_0000, "left_bit0"};
        vecs[4] = '{32'h0, 32'h0000_0001, 1'b0, 64'h0200_0000_0000_0000, "right_bit0"};
        vecs[5] = '{32'h8000_0000, 32'h0, 1'b0, 64'h0000_0000_0000_0040, "left_bit31"};
        vecs[6] = '{32'h0, 32'h8000_0000, 1'b0, 64'h0000_0000_0000_0080, "right_bit31"};
        vecs[7] = '{32'h0000_0001, 32'h0, 1'b1, 64'h0200_0000_0000_0000, "swap_bit0"};
        vecs[8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, "all_ones"};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        left_half = '0; right_half = '0; swap_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(1'b0));
        chk("rst_output_text", output_text, 64'h0);
        chk("rst_blk_cnt", 64'(blk_cnt), 64'(16'h0));
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_in_ready", 64'(in_ready), 64'(1'b1));

        // Directed vectors: one cycle of latency, then popped.
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            left_half = vecs[i].l; right_half = vecs[i].r; swap_en = vecs[i].s;
            cur_exp = vecs[i].exp; in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk({vecs[i].nm, "_valid"}, 64'(out_valid), 64'(1'b1));
            chk(vecs[i].nm, output_text, vecs[i].exp);
            @(posedge clk); #1;
            if (i == 0) chk("blk_after_first", 64'(blk_cnt), 64'(16'h1));
            chk({vecs[i].nm, "_drained"}, 64'(out_valid), 64'(1'b0));
        end
        chk("blk_after_vectors", 64'(blk_cnt), 64'(exp_blk));

        // Round trip through the initial permutation.
        for (int i = 0; i < 1000; i++) begin
            x = {$urandom, $urandom};
            p = ip_of(x);
            push_blk(p[63:32], p[31:0], 1'b0, x);
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rt_drained", 64'(exp_q.size()), 64'h0);

        // Backpressure: A and B fill the FIFO, C is held off.
        out_ready = 1'b0;
        p = ip_of(64'hA0A0_A0A0_A0A0_A0A0);
        push_blk(p[63:32], p[31:0], 1'b0, 64'hA0A0_A0A0_A0A0_A0A0);
        p = ip_of(64'hB1B1_B1B1_B1B1_B1B1);
        push_blk(p[63:32], p[31:0], 1'b0, 64'hB1B1_B1B1_B1B1_B1B1);
        p = ip_of(64'hC2C2_C2C2_C2C2_C2C2);
        left_half = p[63:32]; right_half = p[31:0]; swap_en = 1'b0;
        cur_exp = 64'hC2C2_C2C2_C2C2_C2C2; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("bp_in_ready_low", 64'(in_ready), 64'(1'b0));
            chk("bp_head_stable", output_text, 64'hA0A0_A0A0_A0A0_A0A0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        push_blk(p[63:32], p[31:0], 1'b0, 64'hC2C2_C2C2_C2C2_C2C2);
        repeat (3) @(posedge clk);
        #1;
        chk("bp_drained", 64'(exp_q.size()), 64'h0);
        chk("bp_out_valid_low", 64'(out_valid), 64'(1'b0));

        // Full-rate stream, alternating swap.
        p0 = pop_cnt; s0 = stall_cnt; c0 = cyc;
        for (int i = 0; i < 50; i++) begin
            x = {$urandom, $urandom};
            p = ip_of(x);
            if (i % 2 == 1) push_blk(p[31:0], p[63:32], 1'b1, x);
            else            push_blk(p[63:32], p[31:0], 1'b0, x);
        end
        chk("stream_cycles", 64'(cyc - c0), 64'd50);
        @(posedge clk); #1;
        chk("stream_pops", 64'(pop_cnt - p0), 64'd50);
        chk("stream_no_stall", 64'(stall_cnt - s0), 64'd0);

        // Reset with two blocks buffered.
        out_ready = 1'b0;
        push_blk(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 64'h0);
        push_blk(32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b1, 64'h0);
        chk("mid_buffered", 64'(out_valid), 64'(1'b1));
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'(1'b0));
        chk("mid_rst_blk_cnt", 64'(blk_cnt), 64'(16'h0));
        chk("mid_rst_output_text", output_text, 64'h0);
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("mid_rel_in_ready", 64'(in_ready), 64'(1'b1));
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("mid_no_stale", 64'(out_valid), 64'(1'b0));

        // Counter wrap: 65534 pops from zero, then three more.
        for (int i = 0; i < 65534; i++) begin
            if (i % 2 == 1) push_blk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
            else            push_blk(32'h0, 32'h0, 1'b1, 64'h0);
        end
        @(posedge clk); #1;
        chk("blk_preset", 64'(blk_cnt), 64'(16'hFFFE));
        for (int i = 0; i < 3; i++) begin
            push_blk(32'h0000_0080, 32'h0, 1'b0, 64'h1);
        end
        @(posedge clk); #1;
        chk("blk_wrap", 64'(blk_cnt), 64'(16'h0001));
        chk("blk_wrap_model", 64'(blk_cnt), 64'(exp_blk));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/des_final_permutation.md
# des_final_permutation

Output stage of the DES datapath. Accepts the round-16 halves (L16, R16), applies the optional pre-output swap and the final permutation (IP⁻¹), and presents the 64-bit result through a valid/ready handshake. Buffering is a small registered FIFO, so the round engine can hand off a block and start the next one without waiting for the downstream consumer. The permutation is the exact inverse of the team's initial-permutation bit mapping: feeding that stage's halves straight in with swap disabled returns the original 64-bit word.

## Interface
- DEPTH, 2, FIFO entries; power of two, ≥2
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  left_half/right_half/swap_en valid
- in_ready  out  1  stage can accept a block this cycle
- left_half  in  32  L16
- right_half  in  32  R16
- swap_en  in  1  1: pre-output = {right_half,left_half}; 0: {left_half,right_half}; sampled with the block
- out_valid  out  1  output_text valid
- out_ready  in  1  consumer accepts output_text
- output_text  out  64  permuted block, registered
- blk_cnt  out  16  blocks delivered since reset, wraps

## Operation
- Pre-output word pre[63:0] = swap_en ? {right_half,left_half} : {left_half,right_half}.
- output_text[j] = pre[FP[j]-1] for j = 0..63, where FP[0..63] = 40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31, 38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29, 36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27, 34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25.
- Permutation is computed on the input side; the FIFO stores the permuted 64-bit words.
- Push when in_valid && in_ready. Pop when out_valid && out_ready.
- FIFO: write pointer, read pointer (log2(DEPTH) bits, wrap naturally), and occupancy count 0..DEPTH.
- in_ready = (count != DEPTH). It depends only on the registered count, with no combinational path from out_ready.
- out_valid = (count != 0). output_text = mem[rd_ptr], held stable while out_valid && !out_ready.
- Simultaneous push and pop: count unchanged, both pointers advance. This is legal at every occupancy except full, where no push is possible.
- blk_cnt increments by 1 on each pop and wraps 0xFFFF → 0x0000.
- in_valid while !in_ready: block is not captured; the producer must hold it.

## Timing
- Reset (async assert): count = 0, pointers = 0, out_valid = 0, in_ready = 1 (the first cycle after deassert), output_text = 64'h0, blk_cnt = 0. FIFO memory contents need not be cleared.
- Latency: a block pushed at edge N is on output_text with out_valid = 1 after edge N (1 cycle) if the FIFO was empty.
- Throughput: 1 block/cycle sustained when out_ready is held high.
- Full (count = DEPTH): in_ready = 0 in the cycle after the filling push. It returns to 1 in the cycle after the first pop.
- Empty with push and no pop: out_valid rises next cycle. The same word is never popped twice.
- Reset mid-operation: all buffered blocks are discarded immediately. out_valid drops asynchronously.

## Test plan
- Single bit: left = 32'h80, right = 0, swap_en = 0 → output_text = 64'h1, out_valid 1 cycle later, blk_cnt = 1 after the pop.
- Swap: left = 32'h80, right = 0, swap_en = 1 → output_text = 64'h2. Also left = 0, right = 32'h80, swap_en = 0 → 64'h2.
- Round trip: for 1000 random x, drive the halves of the team's initial permutation of x with swap_en = 0 → output_text == x, in order.
- Backpressure: out_ready = 0, push 3 blocks A, B, C → A and B accepted, in_ready = 0 while C is held. Raise out_ready → A, B, C emerge in order, output_text stable while stalled.
- Full-rate stream: out_ready = 1, push 50 back-to-back blocks → 50 outputs on consecutive cycles, in_ready never drops. Preset blk_cnt to 0xFFFE via 65534 pops and push 3 more → blk_cnt wraps to 0x0001.
- Reset mid-stream: with 2 blocks buffered, assert rst for 1 cycle → out_valid = 0 immediately, blk_cnt = 0, in_ready = 1 after release, and no stale block is ever emitted.
